// File: rtl/trace_line_checker_if.sv
// trace_line_checker_if: character stream in, parsed record report out.
interface trace_line_checker_if #(
   parameter int CNT_W = 16
);
   logic [7:0]       i_char;
   logic [15:0]      i_freq;
   logic [1:0]       o_format_type;
   logic [3:0]       o_error_code;
   logic [CNT_W-1:0] o_record_count;
   modport master (output i_char, i_freq, input o_format_type, o_error_code, o_record_count);
   modport slave (input i_char, i_freq, output o_format_type, o_error_code, o_record_count);
endinterface

// File: rtl/trace_line_checker.sv
// trace_line_checker: parses CPU write-back trace records one ASCII char per clock
// and reports format, semantic error vector and a running record count.
module trace_line_checker #(
   parameter int          TIME_DIGITS = 4,
   parameter int          REG_DIGITS  = 4,
   parameter logic [31:0] PC_MIN      = 32'h0000_3000,
   parameter logic [31:0] PC_MAX      = 32'h0000_4FFF,
   parameter logic [31:0] ADDR_MIN    = 32'h0000_0000,
   parameter logic [31:0] ADDR_MAX    = 32'h0000_2FFF,
   parameter int          REG_COUNT   = 32,
   parameter int          CNT_W       = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   trace_line_checker_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_REG, S_ADDR,
      S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_SP4
   } state_t;
   localparam logic [7:0] TD = 8'(TIME_DIGITS);
   localparam logic [7:0] RD = 8'(REG_DIGITS);
   state_t           r_state, w_state;
   logic [7:0]       r_cnt, w_cnt;
   logic [31:0]      r_time, w_time, r_pc, w_pc, r_addr, w_addr;
   logic [15:0]      r_reg, w_reg;
   logic             r_mem, w_mem, w_acc;
   logic [1:0]       r_fmt;
   logic [3:0]       r_err, w_err;
   logic [CNT_W-1:0] r_count;
   logic [7:0]       w_c;
   logic             w_dec, w_lc, w_uc, w_hex, w_sp, w_terr;
   logic [3:0]       w_nib;
   logic [15:0]      w_half;
   logic [32:0]      w_pc_lo, w_pc_hi, w_ad_lo, w_ad_hi;
   assign w_c   = bus.i_char;
   assign w_dec = w_c >= "0" && w_c <= "9";
   assign w_lc  = w_c >= "a" && w_c <= "f";
   assign w_uc  = w_c >= "A" && w_c <= "F";
   assign w_hex = w_dec || w_lc || w_uc;
   assign w_sp  = w_c == " ";
   assign w_nib = w_dec ? 4'(w_c - 8'h30) : w_lc ? 4'(w_c - 8'h57) : 4'(w_c - 8'h37);
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_time  = r_time;
      w_pc    = r_pc;
      w_addr  = r_addr;
      w_reg   = r_reg;
      w_mem   = r_mem;
      w_acc   = 1'b0;
      if (w_c == "^") begin
         w_state = S_TIME;
         w_cnt   = '0;
         w_time  = '0;
         w_pc    = '0;
         w_addr  = '0;
         w_reg   = '0;
         w_mem   = 1'b0;
      end else begin
         w_state = S_IDLE;
         case (r_state)
            S_TIME:
               if (w_dec && r_cnt < TD) begin
                  w_state = S_TIME;
                  w_cnt   = r_cnt + 8'd1;
                  w_time  = r_time * 32'd10 + 32'(w_nib);
               end else if (w_c == "@" && r_cnt != 8'd0) begin
                  w_state = S_PC;
                  w_cnt   = '0;
               end
            S_PC:
               if (w_hex && r_cnt < 8'd8) begin
                  w_state = S_PC;
                  w_cnt   = r_cnt + 8'd1;
                  w_pc    = {r_pc[27:0], w_nib};
               end else if (w_c == ":" && r_cnt == 8'd8) w_state = S_COLON;
            S_COLON: w_state = w_sp ? S_SP1 : S_IDLE;
            S_SP1: begin
               w_state = w_sp ? S_SP1 : w_c == "$" ? S_REG : w_c == "*" ? S_ADDR : S_IDLE;
               w_cnt   = '0;
               w_mem   = w_c == "*";
            end
            S_REG:
               if (w_dec && r_cnt < RD) begin
                  w_state = S_REG;
                  w_cnt   = r_cnt + 8'd1;
                  w_reg   = r_reg * 16'd10 + 16'(w_nib);
               end else if ((w_sp || w_c == "<") && r_cnt != 8'd0) w_state = w_sp ? S_SP2 : S_LT;
            S_ADDR:
               if (w_hex && r_cnt < 8'd8) begin
                  w_state = S_ADDR;
                  w_cnt   = r_cnt + 8'd1;
                  w_addr  = {r_addr[27:0], w_nib};
               end else if ((w_sp || w_c == "<") && r_cnt == 8'd8) w_state = w_sp ? S_SP2 : S_LT;
            S_SP2: w_state = w_sp ? S_SP2 : w_c == "<" ? S_LT : S_IDLE;
            S_LT: w_state = w_c == "=" ? S_EQ : S_IDLE;
            S_EQ, S_SP3: begin
               w_state = w_sp ? S_SP3 : w_hex ? S_DATA : S_IDLE;
               w_cnt   = 8'd1;
            end
            S_DATA:
               if (w_hex && r_cnt < 8'd8) begin
                  w_state = S_DATA;
                  w_cnt   = r_cnt + 8'd1;
               end else if (r_cnt == 8'd8) begin
                  w_state = w_sp ? S_SP4 : S_IDLE;
                  w_acc   = w_c == "#";
               end
            S_SP4: begin
               w_state = w_sp ? S_SP4 : S_IDLE;
               w_acc   = w_c == "#";
            end
            default: ;
         endcase
      end
   end
   // Range checks via 33-bit borrow so constant-zero bounds need no special case
   assign w_pc_lo = {1'b0, r_pc} - {1'b0, PC_MIN};
   assign w_pc_hi = {1'b0, PC_MAX} - {1'b0, r_pc};
   assign w_ad_lo = {1'b0, r_addr} - {1'b0, ADDR_MIN};
   assign w_ad_hi = {1'b0, ADDR_MAX} - {1'b0, r_addr};
   assign w_half  = bus.i_freq >> 1;
   assign w_terr  = w_half != 16'd0 && (r_time % {16'd0, w_half}) != 32'd0;
   assign w_err   = {!r_mem && {16'd0, r_reg} >= 32'(REG_COUNT),
                     r_mem && (w_ad_lo[32] || w_ad_hi[32] || r_addr[1:0] != 2'd0),
                     w_pc_lo[32] || w_pc_hi[32] || r_pc[1:0] != 2'd0,
                     w_terr};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_time  <= '0;
         r_pc    <= '0;
         r_addr  <= '0;
         r_reg   <= '0;
         r_mem   <= 1'b0;
         r_fmt   <= '0;
         r_err   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_time  <= w_time;
         r_pc    <= w_pc;
         r_addr  <= w_addr;
         r_reg   <= w_reg;
         r_mem   <= w_mem;
         r_fmt   <= w_acc ? (r_mem ? 2'd2 : 2'd1) : 2'd0;
         r_err   <= w_acc ? w_err : 4'd0;
         r_count <= r_count + CNT_W'(w_acc);
      end
   end
   assign bus.o_format_type  = r_fmt;
   assign bus.o_error_code   = r_err;
   assign bus.o_record_count = r_count;
endmodule

// File: tb/tb_trace_line_checker.sv
// tb_trace_line_checker: random and directed trace records checked by a string-level
// reference parser through a scoreboard queue.
module tb_trace_line_checker;
   localparam int          CW       = 4;
   localparam int          TD       = 4;
   localparam int          RD       = 4;
   localparam int          RC       = 32;
   localparam logic [31:0] PC_MIN   = 32'h3000;
   localparam logic [31:0] PC_MAX   = 32'h4FFF;
   localparam logic [31:0] ADDR_MIN = 32'h0;
   localparam logic [31:0] ADDR_MAX = 32'h2FFF;
   typedef struct packed {
      logic [1:0]    fmt;
      logic [3:0]    err;
      logic [CW-1:0] cnt;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_cnt = '0;
   logic [CW-1:0] mon_cnt = '0;
   bit done = 1'b0;
   always #5 clk = ~clk;
   trace_line_checker_if #(.CNT_W(CW)) bus();
   trace_line_checker #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   function automatic bit is_dec(input logic [7:0] c);
      return c >= 8'h30 && c <= 8'h39;
   endfunction
   function automatic bit is_hex(input logic [7:0] c);
      return is_dec(c) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
   endfunction
   function automatic logic [3:0] hv(input logic [7:0] c);
      return is_dec(c) ? 4'(c - 8'h30) : (c >= 8'h61) ? 4'(c - 8'h57) : 4'(c - 8'h37);
   endfunction
   function automatic bit at(input string s, input int i, input logic [7:0] c);
      return i < s.len() && s[i] == c;
   endfunction
   // Reference: a record is the text after the last '^', matched field by field
   function automatic void model(input string s, input logic [15:0] f, output bit ok,
                                 output logic [1:0] fmt, output logic [3:0] err);
      int st = 0, i, n, L = s.len();
      logic [31:0] tm = 0, pc = 0, ad = 0, half;
      logic [15:0] rg = 0;
      bit mem = 0;
      ok = 0; fmt = 0; err = 0;
      for (int k = 0; k < L; k++) if (s[k] == "^") st = k;
      if (!at(s, st, "^")) return;
      i = st + 1; n = 0;
      while (i < L && is_dec(s[i])) begin tm = tm * 10 + 32'(hv(s[i])); n++; i++; end
      if (n < 1 || n > TD || !at(s, i, "@")) return;
      i++; n = 0;
      while (i < L && is_hex(s[i])) begin pc = {pc[27:0], hv(s[i])}; n++; i++; end
      if (n != 8 || !at(s, i, ":") || !at(s, i + 1, " ")) return;
      i += 2;
      while (at(s, i, " ")) i++;
      if (at(s, i, "*")) mem = 1;
      else if (!at(s, i, "$")) return;
      i++; n = 0;
      if (mem) begin
         while (i < L && is_hex(s[i])) begin ad = {ad[27:0], hv(s[i])}; n++; i++; end
         if (n != 8) return;
      end else begin
         while (i < L && is_dec(s[i])) begin rg = rg * 16'd10 + 16'(hv(s[i])); n++; i++; end
         if (n < 1 || n > RD) return;
      end
      while (at(s, i, " ")) i++;
      if (!at(s, i, "<") || !at(s, i + 1, "=")) return;
      i += 2;
      while (at(s, i, " ")) i++;
      n = 0;
      while (i < L && is_hex(s[i])) begin n++; i++; end
      if (n != 8) return;
      while (at(s, i, " ")) i++;
      if (!at(s, i, "#") || i != L - 1) return;
      half = 32'(f) / 2;
      err[0] = half != 0 && tm % half != 0;
      err[1] = pc < PC_MIN || pc > PC_MAX || pc[1:0] != 0;
      err[2] = mem && (longint'(ad) < longint'(ADDR_MIN) || ad > ADDR_MAX || ad[1:0] != 0);
      err[3] = !mem && int'(rg) >= RC;
      fmt = mem ? 2'd2 : 2'd1;
      ok = 1;
   endfunction
   function automatic string hexs(input logic [31:0] v, input int nd);
      string o = "";
      logic [3:0] nb;
      logic [7:0] c;
      for (int k = nd - 1; k >= 0; k--) begin
         nb = 4'(v >> (4 * k));
         c = nb < 4'd10 ? 8'h30 + 8'(nb) : (($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41) + 8'(nb) - 8'd10;
         o = {o, $sformatf("%c", c)};
      end
      return o;
   endfunction
   function automatic string decs(input int v, input int nd);
      string o = "";
      int x = v;
      for (int k = 0; k < nd; k++) begin o = {$sformatf("%0d", x % 10), o}; x /= 10; end
      return o;
   endfunction
   function automatic string sp(input int n);
      string o = "";
      repeat (n) o = {o, " "};
      return o;
   endfunction
   function automatic int nlen();
      return ($urandom_range(0, 9) == 0) ? 7 + 2 * int'($urandom_range(0, 1)) : 8;
   endfunction
   function automatic string gen_rec();
      string s, set = "0 aZg$*<=@:x";
      logic [31:0] pc, ad;
      int pos, j;
      s = {"^", decs(int'($urandom_range(0, 9999)), int'($urandom_range(1, 5))), "@"};
      pc = 32'h2FF0 + 32'($urandom_range(0, 'h2020));
      if ($urandom_range(0, 2) != 0) pc[1:0] = 2'd0;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      s = {s, hexs(pc, nlen()), ":", sp(int'($urandom_range(1, 2)))};
      if ($urandom_range(0, 1) == 1) begin
         ad = 32'($urandom_range(0, 'h3010));
         if ($urandom_range(0, 2) != 0) ad[1:0] = 2'd0;
         s = {s, "*", hexs(ad, nlen())};
      end else s = {s, "$", decs(int'($urandom_range(0, 40)), int'($urandom_range(1, 5)))};
      s = {s, sp(int'($urandom_range(0, 2))), "<=", sp(int'($urandom_range(0, 2))), hexs($urandom, nlen()),
           sp(int'($urandom_range(0, 2))), "#"};
      if ($urandom_range(0, 7) == 0) begin
         pos = int'($urandom_range(1, s.len() - 2));
         j = int'($urandom_range(0, set.len() - 1));
         s = {s.substr(0, pos - 1), set.substr(j, j), s.substr(pos + 1, s.len() - 1)};
      end
      return s;
   endfunction
   task automatic put(input logic [7:0] c);
      @(negedge clk);
      bus.i_char = c;
   endtask
   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) put(s[i]);
   endtask
   task automatic run_rec(input string s);
      bit ok;
      logic [1:0] f;
      logic [3:0] er;
      model(s, bus.i_freq, ok, f, er);
      if (ok) begin
         exp_cnt = exp_cnt + 1'b1;
         q.push_back(exp_t'({f, er, exp_cnt}));
      end
      send(s);
      put(8'h0A);
      put(8'h0A);
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         checks++;
         if (bus.o_format_type != 0 || bus.o_error_code != 0 || bus.o_record_count != 0) begin
            errors++;
            $display("FAIL reset_state fmt=%0d err=%b cnt=%0d required 0 0000 0",
                     bus.o_format_type, bus.o_error_code, bus.o_record_count);
         end
         mon_cnt = '0;
      end else if (bus.o_format_type != 0) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record fmt=%0d err=%b cnt=%0d required no record",
                     bus.o_format_type, bus.o_error_code, bus.o_record_count);
         end else begin
            e = q.pop_front();
            if (bus.o_format_type != e.fmt || bus.o_error_code != e.err || bus.o_record_count != e.cnt) begin
               errors++;
               $display("FAIL record fmt=%0d err=%b cnt=%0d required fmt=%0d err=%b cnt=%0d",
                        bus.o_format_type, bus.o_error_code, bus.o_record_count, e.fmt, e.err, e.cnt);
            end
            mon_cnt = e.cnt;
         end
      end else begin
         checks++;
         if (bus.o_error_code != 0 || bus.o_record_count != mon_cnt) begin
            errors++;
            $display("FAIL idle_state err=%b cnt=%0d required err=0000 cnt=%0d",
                     bus.o_error_code, bus.o_record_count, mon_cnt);
         end
      end
      if (done) begin
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_records pending=%0d required 0", q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end
   initial begin
      logic [15:0] fl[7] = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd6, 16'd10, 16'd16};
      bus.i_char = 8'h0A;
      bus.i_freq = 16'd2;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      run_rec("^242@000030f4: $31 <= 12345678#");
      run_rec("^338@00003130: *00000088 <= ffffb528#");
      run_rec("^338@00003130: *00000088 <= Ffffb528 #");
      run_rec("^242@000030f4: $31 <= 123215#");
      run_rec("^242@000030f4: $31 <= 1234567890#");
      run_rec("^242@000030f4: $31 <=#");
      run_rec("^242@000030f4: $31 <= 1234g678#");
      run_rec("^12345@000030f4: $31 <= 12345678#");
      bus.i_freq = 16'd4;
      run_rec("^243@000030f5: $32 <= 00000000#");
      run_rec("^242@00003000: *00003000 <= 00000000#");
      run_rec({"^242@0000", "^242@000030f4: $31 <= 12345678#"});
      send("^100@00003000: $1 <= 1234");
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_cnt = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      send("5678#");
      put(8'h0A);
      put(8'h0A);
      run_rec("^200@00003004: $5 <= 0000abcd#");
      for (int n = 0; n < 200; n++) begin
         bus.i_freq = ($urandom_range(0, 7) == 0) ? 16'($urandom) : fl[$urandom_range(0, 6)];
         run_rec(gen_rec());
      end
      repeat (4) put(8'h0A);
      done = 1'b1;
      repeat (4) @(negedge clk);
      $display("FAIL monitor_stalled");
      $fatal(1, "monitor did not finish");
   end
endmodule
